// File: rtl/tamagotchi_button_ctrl.sv
// NEXT/PREV push-button front end for the tamagotchi state FSM: sync, debounce, auto-repeat,
// and wrap-around selection over indices 0..NUM_SEL-1 with one-cycle change_state requests.
module tamagotchi_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int NUM_SEL         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next_raw,
  input  logic       btn_prev_raw,
  input  logic       fsm_dead,
  output logic [2:0] change_state,
  output logic [2:0] sel_idx
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_CNT  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] REP_CNT   = HOLD_W'(REPEAT_CYCLES);
  localparam logic [2:0]        SEL_MAX   = 3'(NUM_SEL - 1);
  localparam logic [2:0]        IDLE_CODE = 3'd7;
  localparam logic [2:0]        RESET_SEL = 3'd2;

  // Bit 0 is NEXT, bit 1 is PREV throughout.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] rep_phase;
  logic [1:0] hold_run;
  logic [1:0] hold_fire;
  logic [1:0] press;
  logic [1:0] btn_evt;

  logic [DB_W-1:0]   db_cnt   [2];
  logic [HOLD_W-1:0] hold_cnt [2];

  logic [2:0] next_sel;
  logic       fire;

  assign raw      = {btn_prev_raw, btn_next_raw};
  assign press    = level & ~level_d;
  assign hold_run = {level[1] & ~level[0], level[0] & ~level[1]} & {2{~fsm_dead}};
  assign btn_evt  = press | hold_fire;

  // The first repeat waits LONG_CYCLES from the press; later ones reload to 1 and wait REPEAT_CYCLES.
  always_comb begin
    hold_fire = '0;
    for (int i = 0; i < 2; i++) begin
      if (hold_run[i]) begin
        hold_fire[i] = rep_phase[i] ? (hold_cnt[i] == REP_CNT) : (hold_cnt[i] == LONG_CNT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_d   <= '0;
      rep_phase <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= ~level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end

        if (!hold_run[i]) begin
          hold_cnt[i]  <= '0;
          rep_phase[i] <= 1'b0;
        end else if (hold_fire[i]) begin
          hold_cnt[i]  <= HOLD_W'(1);
          rep_phase[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
        end
      end
    end
  end

  // Simultaneous NEXT and PREV events cancel; a dead pet swallows everything.
  always_comb begin
    next_sel = sel_idx;
    fire     = 1'b0;
    if (!fsm_dead) begin
      case (btn_evt)
        2'b01: begin
          next_sel = (sel_idx == SEL_MAX) ? 3'd0 : sel_idx + 3'd1;
          fire     = 1'b1;
        end
        2'b10: begin
          next_sel = (sel_idx == 3'd0) ? SEL_MAX : sel_idx - 3'd1;
          fire     = 1'b1;
        end
        default: begin
          next_sel = sel_idx;
          fire     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx      <= RESET_SEL;
      change_state <= IDLE_CODE;
    end else begin
      sel_idx      <= next_sel;
      change_state <= fire ? next_sel : IDLE_CODE;
    end
  end

endmodule

// File: tb/tb_tamagotchi_button_ctrl.sv
// Directed bench for tamagotchi_button_ctrl with short debounce/hold timings; a per-edge
// monitor collects change_state pulses so each stimulus can be judged on its events.
module tb_tamagotchi_button_ctrl;

  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next_raw = 1'b0;
  logic       btn_prev_raw = 1'b0;
  logic       fsm_dead = 1'b0;
  logic [2:0] change_state;
  logic [2:0] sel_idx;

  tamagotchi_button_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .REPEAT_CYCLES  (RC),
    .NUM_SEL        (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_next_raw(btn_next_raw),
    .btn_prev_raw(btn_prev_raw),
    .fsm_dead    (fsm_dead),
    .change_state(change_state),
    .sel_idx     (sel_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic nxt;
    logic prv;
    logic dead;
    int   hold;
    int   idle;
    int   exp_sel;
    int   exp_events;
    int   exp_last;
  } vec_t;

  vec_t vecs [9];

  int         total = 0;
  int         bad = 0;
  int         edge_n = 0;
  int         ev_count = 0;
  int         illegal = 0;
  logic [2:0] ev_last = 3'd7;
  logic [2:0] prev_cs = 3'd7;
  int         ev_edge [$];
  int         ev_val  [$];

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // One clock edge; sample 1 ns later and log any request pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (change_state != 3'd7) begin
      ev_count++;
      ev_last = change_state;
      ev_edge.push_back(edge_n);
      ev_val.push_back(int'(change_state));
      if (change_state == 3'd6 || prev_cs != 3'd7) illegal++;
    end
    prev_cs = change_state;
  endtask

  task automatic clear_monitor();
    edge_n   = 0;
    ev_count = 0;
    illegal  = 0;
    ev_last  = 3'd7;
    ev_edge.delete();
    ev_val.delete();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    btn_next_raw = 1'b0;
    btn_prev_raw = 1'b0;
    fsm_dead     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    prev_cs = 3'd7;
    clear_monitor();
  endtask

  task automatic apply_stimulus(input vec_t v);
    clear_monitor();
    btn_next_raw = v.nxt;
    btn_prev_raw = v.prv;
    fsm_dead     = v.dead;
    repeat (v.hold) tick();
    btn_next_raw = 1'b0;
    btn_prev_raw = 1'b0;
    repeat (v.idle) tick();
    fsm_dead = 1'b0;
  endtask

  initial begin
    int off;
    int exp_edge [5];
    int exp_val  [5];
    int act_edge;
    int act_val;

    // nxt prv dead hold idle sel events last -- starts from sel 3
    vecs[0] = '{1'b1, 1'b0, 1'b0,  3, 21, 3, 0, 7};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10, 14, 4, 1, 4};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 10, 14, 5, 1, 5};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 10, 14, 0, 1, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10, 14, 5, 1, 5};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 10, 14, 4, 1, 4};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 10, 14, 4, 0, 7};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 10, 14, 4, 0, 7};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 10, 14, 3, 1, 3};

    exp_edge = '{7, 27, 32, 37, 42};
    exp_val  = '{3, 4, 5, 0, 1};

    do_reset();
    off = 0;
    repeat (50) begin
      tick();
      if (sel_idx != 3'd2 || change_state != 3'd7) off++;
    end
    check_output("reset_idle_off_cycles", off, 0);
    check_output("reset_sel", int'(sel_idx), 2);

    // Raw NEXT high across edges 1..10: request visible only after edge 7.
    clear_monitor();
    btn_next_raw = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_output($sformatf("latency_edge%0d", e), int'(change_state), (e == 7) ? 3 : 7);
      if (e == 10) btn_next_raw = 1'b0;
    end
    repeat (10) tick();
    check_output("latency_sel", int'(sel_idx), 3);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_sel", i), int'(sel_idx), vecs[i].exp_sel);
      check_output($sformatf("vec%0d_events", i), ev_count, vecs[i].exp_events);
      check_output($sformatf("vec%0d_last", i), int'(ev_last), vecs[i].exp_last);
      check_output($sformatf("vec%0d_illegal", i), illegal, 0);
    end

    // Long hold: press at edge 7, repeats 20 later and every 5 after until release.
    do_reset();
    btn_next_raw = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 38) btn_next_raw = 1'b0;
    end
    check_output("hold_event_count", ev_count, 5);
    for (int k = 0; k < 5; k++) begin
      act_edge = (k < ev_edge.size()) ? ev_edge[k] : -1;
      act_val  = (k < ev_val.size())  ? ev_val[k]  : -1;
      check_output($sformatf("hold_ev%0d_edge", k), act_edge, exp_edge[k]);
      check_output($sformatf("hold_ev%0d_val", k), act_val, exp_val[k]);
    end
    check_output("hold_sel", int'(sel_idx), 1);
    check_output("hold_illegal", illegal, 0);

    // Reset asserted mid-hold, between clock edges, with the button let go at the same time.
    do_reset();
    btn_next_raw = 1'b1;
    repeat (30) tick();
    check_output("midhold_sel_before", int'(sel_idx), 4);
    #3;
    rst          = 1'b1;
    btn_next_raw = 1'b0;
    #1;
    check_output("midhold_async_sel", int'(sel_idx), 2);
    check_output("midhold_async_cs", int'(change_state), 7);
    tick();
    rst = 1'b0;
    prev_cs = 3'd7;
    clear_monitor();
    repeat (40) tick();
    check_output("midhold_events_after", ev_count, 0);
    check_output("midhold_sel_after", int'(sel_idx), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
